// File: rtl/framing_pkg.sv
// Shared types and default sizes for the framing FIFO read-side consumer.
package framing_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DATA_W_DEF    = 32;
    localparam int DEPTH_W_DEF   = 10;
    localparam int FRAME_LEN_DEF = 1024;
    localparam int FCNT_W_DEF    = 16;

    // Sample counters must hold FRAME_LEN itself, not just FRAME_LEN-1.
    localparam int CNT_W_DEF = $clog2(FRAME_LEN_DEF) + 1;

    function automatic int cnt_width(input int frame_len);
        return $clog2(frame_len) + 1;
    endfunction

endpackage

// File: rtl/framing_skid_buf.sv
// Two-entry valid/ready buffer that absorbs the FIFO's one-cycle read latency.
// Entry "head" drives the outputs directly, so the presented sample and its
// sideband are register outputs and hold still under backpressure.
module framing_skid_buf
    import framing_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = DEPTH_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_first_i,
    input  logic              wr_last_i,
    input  logic [IDX_W-1:0]  wr_index_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              first_o,
    output logic              last_o,
    output logic [IDX_W-1:0]  index_o,
    output logic [1:0]        occ_o
);

    localparam int PW = DATA_W + 2 + IDX_W;

    logic [PW-1:0] head_q;
    logic [PW-1:0] tail_q;
    logic [1:0]    occ_q;
    logic [PW-1:0] wr_pl;
    logic          pop;

    assign wr_pl   = {wr_data_i, wr_first_i, wr_last_i, wr_index_i};
    assign valid_o = (occ_q != 2'd0);
    assign pop     = valid_o & ready_i;
    assign occ_o   = occ_q;

    assign {data_o, first_o, last_o, index_o} = head_q;

    // Occupancy and entry update; a write while full would drop a sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            assert (!(wr_i && (occ_q == 2'd2)));
            case ({wr_i, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_q <= wr_pl;
                    else               tail_q <= wr_pl;
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) head_q <= tail_q;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= wr_pl;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= wr_pl;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/framing_1024_frame_reader.sv
// Read-side frame reader: waits for a full frame in the framing FIFO, bursts
// exactly FRAME_LEN reads, and streams them out with first/last/index sideband.
//
// state | meaning
// IDLE  | waiting for en and a full frame in the FIFO; counters cleared
// BURST | issuing reads and emitting samples until the last one is accepted
// DONE  | one cycle; bump the completed-frame counter
module framing_1024_frame_reader
    import framing_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH_W   = DEPTH_W_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int FCNT_W    = FCNT_W_DEF
) (
    input  logic               rd_clk,
    input  logic               rd_rst_n,
    input  logic               en,
    output logic               fifo_rd_en,
    input  logic [DATA_W-1:0]  fifo_rd_data,
    input  logic               fifo_rd_empty,
    input  logic [DEPTH_W:0]   fifo_rd_water_level,
    output logic [DATA_W-1:0]  frm_data,
    output logic               frm_valid,
    input  logic               frm_ready,
    output logic               frm_first,
    output logic               frm_last,
    output logic [DEPTH_W-1:0] frm_index,
    output logic [FCNT_W-1:0]  frame_cnt,
    output logic               busy,
    output logic               underrun_err
);

    localparam int CNT_W = cnt_width(FRAME_LEN);
    localparam int LVL_W = DEPTH_W + 1;

    state_e            state_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [CNT_W-1:0]  emit_cnt_q;
    logic              inflight_q;
    logic              underrun_q;
    logic [FCNT_W-1:0] frame_cnt_q;

    logic [1:0]        occ;
    logic              pop;
    logic              owe;
    logic              space_ok;
    logic              start;
    logic [CNT_W-1:0]  wr_idx;

    assign pop   = frm_valid & frm_ready;
    assign owe   = (issue_cnt_q < CNT_W'(FRAME_LEN));
    assign start = en & (fifo_rd_water_level >= LVL_W'(FRAME_LEN));

    // A slot is free if the buffer plus the read in flight leave room, counting
    // the entry that leaves this cycle.
    assign space_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

    assign fifo_rd_en = (state_q == BURST) & owe & ~fifo_rd_empty & space_ok;

    // The word landing now was issued last cycle, so its index is one behind.
    assign wr_idx = issue_cnt_q - CNT_W'(1);

    assign busy         = (state_q != IDLE);
    assign frame_cnt    = frame_cnt_q;
    assign underrun_err = underrun_q;

    framing_skid_buf #(
        .DATA_W (DATA_W),
        .IDX_W  (DEPTH_W)
    ) u_buf (
        .clk        (rd_clk),
        .rst_n      (rd_rst_n),
        .wr_i       (inflight_q),
        .wr_data_i  (fifo_rd_data),
        .wr_first_i (wr_idx == '0),
        .wr_last_i  (wr_idx == CNT_W'(FRAME_LEN - 1)),
        .wr_index_i (DEPTH_W'(wr_idx)),
        .ready_i    (frm_ready),
        .valid_o    (frm_valid),
        .data_o     (frm_data),
        .first_o    (frm_first),
        .last_o     (frm_last),
        .index_o    (frm_index),
        .occ_o      (occ)
    );

    // Frame sequencing, read/accept counting and sticky underrun flag.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            emit_cnt_q  <= '0;
            inflight_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            inflight_q <= fifo_rd_en;
            case (state_q)
                IDLE: begin
                    issue_cnt_q <= '0;
                    emit_cnt_q  <= '0;
                    if (start) state_q <= BURST;
                end
                BURST: begin
                    if (fifo_rd_en) issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                    if (pop)        emit_cnt_q  <= emit_cnt_q + CNT_W'(1);
                    if (owe && fifo_rd_empty) underrun_q <= 1'b1;
                    // Exit on the accept of the final sample; emit_cnt and the
                    // buffered last flag agree by construction.
                    if (pop && frm_last && (emit_cnt_q == CNT_W'(FRAME_LEN - 1)))
                        state_q <= DONE;
                end
                DONE: begin
                    frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_framing_1024_frame_reader.sv
// Directed/randomized bench for the frame reader with a FIFO model and a
// stream scoreboard derived from FIFO order and frame length.
module tb_framing_1024_frame_reader;

    localparam int DATA_W    = 32;
    localparam int DEPTH_W   = 10;
    localparam int FRAME_LEN = 1024;
    localparam int FCNT_W    = 16;
    localparam int FIFO_CAP  = 1024;

    logic               rd_clk = 1'b0;
    logic               rd_rst_n = 1'b1;
    logic               en = 1'b0;
    logic               fifo_rd_en;
    logic [DATA_W-1:0]  fifo_rd_data = '0;
    logic               fifo_rd_empty;
    logic [DEPTH_W:0]   fifo_rd_water_level;
    logic [DATA_W-1:0]  frm_data;
    logic               frm_valid;
    logic               frm_ready = 1'b0;
    logic               frm_first;
    logic               frm_last;
    logic [DEPTH_W-1:0] frm_index;
    logic [FCNT_W-1:0]  frame_cnt;
    logic               busy;
    logic               underrun_err;

    framing_1024_frame_reader #(
        .DATA_W    (DATA_W),
        .DEPTH_W   (DEPTH_W),
        .FRAME_LEN (FRAME_LEN),
        .FCNT_W    (FCNT_W)
    ) dut (
        .rd_clk              (rd_clk),
        .rd_rst_n            (rd_rst_n),
        .en                  (en),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_empty       (fifo_rd_empty),
        .fifo_rd_water_level (fifo_rd_water_level),
        .frm_data            (frm_data),
        .frm_valid           (frm_valid),
        .frm_ready           (frm_ready),
        .frm_first           (frm_first),
        .frm_last            (frm_last),
        .frm_index           (frm_index),
        .frame_cnt           (frame_cnt),
        .busy                (busy),
        .underrun_err        (underrun_err)
    );

    always #5 rd_clk = ~rd_clk;

    // FIFO model: mem holds every word ever produced, in order.
    logic [DATA_W-1:0] mem [0:16383];
    int  n_pushed = 0;
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    logic force_empty = 1'b0;

    assign fifo_rd_water_level = (DEPTH_W+1)'(wr_ptr - rd_ptr);
    assign fifo_rd_empty       = (wr_ptr == rd_ptr) || force_empty;

    // Producer side: one word per cycle into the FIFO while it has room.
    always @(negedge rd_clk)
        if ((wr_ptr < n_pushed) && ((wr_ptr - rd_ptr) < FIFO_CAP)) wr_ptr <= wr_ptr + 1;

    // FIFO read port: data appears the cycle after the read enable.
    always @(posedge rd_clk)
        if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end

    // Reference model state
    int n_checks = 0;
    int n_pass   = 0;
    int exp_ptr = 0;
    int acc_in_frame = 0;
    int issued = 0;
    int accepted = 0;
    int frame_rd = 0;
    int cyc = 0;
    int valid_cycles = 0;
    int first_acc_cyc = -1;
    int last_acc_cyc = -1;
    bit hold_prev = 0;
    logic [DATA_W-1:0]  prev_data;
    logic [DEPTH_W-1:0] prev_index;
    bit force_req = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_words(input int n, input bit ramp);
        for (int i = 0; i < n; i++) begin
            mem[n_pushed] = ramp ? DATA_W'(i) : DATA_W'($urandom);
            n_pushed++;
        end
    endtask

    // One clock: drive at negedge, sample/check just after, return before posedge.
    task automatic tick(input int ready_mode);
        bit p;
        @(negedge rd_clk);
        frm_ready   = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        force_empty = force_req;
        #1;
        cyc++;
        p = frm_valid && frm_ready;
        if (hold_prev) begin
            check("hold_valid", frm_valid, 1);
            check("hold_data", frm_data, prev_data);
            check("hold_index", frm_index, prev_index);
        end
        if (fifo_rd_en) begin
            check("rd_en_nonempty", fifo_rd_empty, 0);
            check("rd_en_space", ((issued - accepted) < (2 + int'(p))), 1);
            issued++;
            frame_rd++;
        end
        if (frm_valid) valid_cycles++;
        if (p) begin
            check("data", frm_data, mem[exp_ptr]);
            check("index", frm_index, acc_in_frame);
            check("first", frm_first, (acc_in_frame == 0));
            check("last", frm_last, (acc_in_frame == FRAME_LEN - 1));
            exp_ptr++;
            accepted++;
            acc_in_frame = (acc_in_frame == FRAME_LEN - 1) ? 0 : acc_in_frame + 1;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
        end
        hold_prev  = frm_valid && !frm_ready;
        prev_data  = frm_data;
        prev_index = frm_index;
    endtask

    task automatic run_frames(input int target, input int ready_mode, input int budget);
        int n = 0;
        while ((int'(frame_cnt) != target) && (n < budget)) begin
            tick(ready_mode);
            n++;
        end
        check("frame_cnt_reached", frame_cnt, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},  fifo_rd_en, 0);
        check({tag, "_valid"},  frm_valid, 0);
        check({tag, "_data"},   frm_data, 0);
        check({tag, "_first"},  frm_first, 0);
        check({tag, "_last"},   frm_last, 0);
        check({tag, "_index"},  frm_index, 0);
        check({tag, "_fcnt"},   frame_cnt, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_underr"}, underrun_err, 0);
    endtask

    initial begin
        int n;
        int rd_before;
        int acc_before;

        // Reset
        #2 rd_rst_n = 1'b0;
        #5;
        check_reset_outputs("reset");
        @(negedge rd_clk);
        rd_rst_n = 1'b1;

        // Ramp frame, ready held high
        push_words(FRAME_LEN, 1'b1);
        en = 1'b1;
        frame_rd = 0; valid_cycles = 0; first_acc_cyc = -1;
        run_frames(1, 1, 4000);
        check("ramp_rd_count", frame_rd, FRAME_LEN);
        check("ramp_valid_cycles", valid_cycles, FRAME_LEN);
        check("ramp_back_to_back", last_acc_cyc - first_acc_cyc, FRAME_LEN - 1);
        check("ramp_busy_after", busy, 0);
        check("ramp_no_underrun", underrun_err, 0);

        // Water level one short of a frame, then the last word arrives
        push_words(FRAME_LEN - 1, 1'b0);
        n = 0;
        while ((wr_ptr != n_pushed) && (n < 3000)) begin tick(1); n++; end
        check("wl_filled", fifo_rd_water_level, FRAME_LEN - 1);
        rd_before = issued;
        repeat (50) tick(1);
        check("wl_no_rd", issued, rd_before);
        check("wl_not_busy", busy, 0);
        push_words(1, 1'b0);
        tick(1);
        check("wl_full_level", fifo_rd_water_level, FRAME_LEN);
        check("wl_still_idle", busy, 0);
        tick(1);
        check("wl_start_busy", busy, 1);
        check("wl_start_rd", fifo_rd_en, 1);
        run_frames(2, 1, 3000);

        // Two frames under random backpressure
        push_words(2 * FRAME_LEN, 1'b0);
        frame_rd = 0;
        acc_before = accepted;
        run_frames(4, 2, 14000);
        check("rand_rd_count", frame_rd, 2 * FRAME_LEN);
        check("rand_accepted", accepted - acc_before, 2 * FRAME_LEN);

        // en dropped mid-frame: current frame completes, next never starts
        push_words(2 * FRAME_LEN, 1'b0);
        n = 0;
        while ((acc_in_frame < 300) && (n < 4000)) begin tick(1); n++; end
        check("endrop_reached_300", acc_in_frame, 300);
        en = 1'b0;
        run_frames(5, 1, 3000);
        check("endrop_busy_after", busy, 0);
        rd_before = issued;
        repeat (100) tick(1);
        check("endrop_no_new_rd", issued, rd_before);
        check("endrop_idle", busy, 0);
        check("endrop_fcnt", frame_cnt, 5);
        check("endrop_level", fifo_rd_water_level, FRAME_LEN);

        // Underrun: FIFO reports empty for 5 cycles at read 500
        en = 1'b1;
        frame_rd = 0;
        n = 0;
        while ((frame_rd < 500) && (n < 3000)) begin tick(1); n++; end
        check("underrun_pre", underrun_err, 0);
        force_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("underrun_rd_held", fifo_rd_en, 0);
        end
        force_req = 1'b0;
        check("underrun_flag", underrun_err, 1);
        run_frames(6, 1, 3000);
        check("underrun_sticky", underrun_err, 1);
        check("underrun_rd_count", frame_rd, FRAME_LEN);

        // Asynchronous reset at sample 700
        push_words(FRAME_LEN, 1'b0);
        n = 0;
        while ((acc_in_frame < 700) && (n < 4000)) begin tick(1); n++; end
        check("rst_reached_700", acc_in_frame, 700);
        #2 rd_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_ptr = rd_ptr;
        issued = accepted;
        acc_in_frame = 0;
        hold_prev = 0;
        frame_rd = 0;
        @(negedge rd_clk);
        #1;
        check("midrst_hold_valid", frm_valid, 0);
        exp_ptr = rd_ptr;
        @(negedge rd_clk);
        rd_rst_n = 1'b1;
        push_words(FRAME_LEN, 1'b0);
        run_frames(1, 2, 8000);
        check("post_rst_rd_count", frame_rd, FRAME_LEN);
        check("post_rst_underrun", underrun_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
